fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 32 +++
 rtl/fetch_stage_if_id_reg.sv | 61 ++++++
 rtl/fetch_stage.sv | 181 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Package for the fetch stage.
// Holds the fetch-state encoding, the NOP opcode, the vector word addresses
// (reset vector at words 0/1, interrupt vector at words 2/3), the default
// reset PC and a helper that treats anything other than a clean 1 as 0.
// Optional feature macro: FETCH_RESET_VECTOR_EN (reset-vector states only exist
// when it is defined).
package fetch_pkg;

  typedef enum logic [2:0] {
`ifdef FETCH_RESET_VECTOR_EN
    RST_VEC_LO = 3'd0,
    RST_VEC_HI = 3'd1,
`endif
    RUN        = 3'd2,
    INT_VEC_LO = 3'd3,
    INT_VEC_HI = 3'd4
  } fetch_state_t;

  localparam logic [15:0] NOP_OP           = 16'h0000;
  localparam logic [31:0] RST_VEC_LO_ADDR  = 32'h0000_0000;
  localparam logic [31:0] RST_VEC_HI_ADDR  = 32'h0000_0001;
  localparam logic [31:0] INT_VEC_LO_ADDR  = 32'h0000_0002;
  localparam logic [31:0] INT_VEC_HI_ADDR  = 32'h0000_0003;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0004;

  // A control line from the interrupt unit counts only when it is exactly 1;
  // x and z (unit absent or tristated) read as inactive.
  function automatic logic is_one(input logic v);
    return (v === 1'b1);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, reset (sync, active-low)  - clock and reset (reset clears to NOP, pc 0, invalid)
//   enable                         - 0 holds every bit
//   load / flush / hold            - update controls, priority flush > hold > load
//   instruction_in, pc_in          - word and address captured on load
//   instruction, pc, valid         - registered outputs to decode
module if_id_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic        flush,
  input  logic        hold,
  input  logic [15:0] instruction_in,
  input  logic [31:0] pc_in,
  output logic [15:0] instruction,
  output logic [31:0] pc,
  output logic        valid
);

  logic [15:0] instruction_r;
  logic [31:0] pc_r;
  logic        valid_r;

  // IF/ID register update: flush inserts a bubble, hold freezes, load captures
  always_ff @(posedge clk) begin
    if (!reset) begin
      instruction_r <= NOP_OP;
      pc_r          <= 32'h0000_0000;
      valid_r       <= 1'b0;
    end else if (!enable) begin
      instruction_r <= instruction_r;
      pc_r          <= pc_r;
      valid_r       <= valid_r;
    end else if (flush) begin
      instruction_r <= NOP_OP;
      pc_r          <= pc_in;
      valid_r       <= 1'b0;
    end else if (hold) begin
      instruction_r <= instruction_r;
      pc_r          <= pc_r;
      valid_r       <= valid_r;
    end else if (load) begin
      instruction_r <= instruction_in;
      pc_r          <= pc_in;
      valid_r       <= 1'b1;
    end else begin
      instruction_r <= instruction_r;
      pc_r          <= pc_r;
      valid_r       <= valid_r;
    end
  end

  assign instruction = instruction_r;
  assign pc          = pc_r;
  assign valid       = valid_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with reset/interrupt vector loading.
// Ports:
//   clk, reset (sync, active-low), enable (0 = hold everything)
//   icu_req, icu_stall, icu_instruction, icu_pc_load - interrupt unit controls
//   hazard_stall, branch_taken, branch_target        - later-stage controls
//   imem_addr (comb), imem_data                      - instruction memory port
//   if_id_instruction, if_id_pc, if_id_valid         - registered IF/ID outputs
//   saved_pc                                         - return address for PUSH PC
// Macro FETCH_RESET_VECTOR_EN: when defined, reset fetches the start PC from
// words 0/1; otherwise reset starts fetching at DEFAULT_RESET_PC directly.
module fetch_stage
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        icu_req,
  input  logic        icu_stall,
  input  logic [15:0] icu_instruction,
  input  logic        icu_pc_load,
  input  logic        hazard_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] if_id_instruction,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic [31:0] saved_pc
);

`ifdef FETCH_RESET_VECTOR_EN
  localparam fetch_state_t RESET_STATE = RST_VEC_LO;
  localparam logic [31:0]  RESET_PC    = 32'h0000_0000;
`else
  localparam fetch_state_t RESET_STATE = RUN;
  localparam logic [31:0]  RESET_PC    = DEFAULT_RESET_PC;
`endif

  fetch_state_t state_r;
  logic [31:0]  pc_r;
  logic [31:0]  saved_pc_r;

  logic         req_s;
  logic         stall_s;
  logic         run_s;
  logic         load_s;
  logic         flush_s;
  logic         hold_s;
  logic [15:0]  load_instr_s;
  logic [31:0]  pc_next_s;
  logic [31:0]  saved_next_s;

  assign req_s   = is_one(icu_req);
  assign stall_s = is_one(icu_stall);
  assign run_s   = (state_r == RUN);

  // RUN-state decode: next PC and IF/ID control, highest priority first
  always_comb begin
    pc_next_s    = pc_r;
    load_s       = 1'b0;
    flush_s      = 1'b0;
    hold_s       = 1'b0;
    load_instr_s = imem_data;
    if (!run_s) begin
      flush_s = 1'b1;
    end else if (icu_pc_load) begin
      flush_s = 1'b1;
    end else if (branch_taken) begin
      flush_s   = 1'b1;
      pc_next_s = branch_target;
    end else if (hazard_stall) begin
      hold_s = 1'b1;
    end else if (stall_s) begin
      flush_s = 1'b1;
    end else if (req_s) begin
      load_s       = 1'b1;
      load_instr_s = icu_instruction;
    end else begin
      load_s    = 1'b1;
      pc_next_s = pc_r + 32'd1;
    end
  end

  // Return-address tracking: saved_pc follows the next PC (first address not
  // yet fetched) and is frozen during an injection window except for branches.
  always_comb begin
    saved_next_s = saved_pc_r;
    if (!run_s) begin
      saved_next_s = saved_pc_r;
    end else if (req_s || stall_s) begin
      if (branch_taken) begin
        saved_next_s = branch_target;
      end else begin
        saved_next_s = saved_pc_r;
      end
    end else if (hazard_stall && !icu_pc_load && !branch_taken) begin
      saved_next_s = saved_pc_r;
    end else begin
      saved_next_s = pc_next_s;
    end
  end

  // Memory address: vector word in vector states, PC otherwise
  always_comb begin
    imem_addr = pc_r;
    case (state_r)
`ifdef FETCH_RESET_VECTOR_EN
      RST_VEC_LO: imem_addr = RST_VEC_LO_ADDR;
      RST_VEC_HI: imem_addr = RST_VEC_HI_ADDR;
`endif
      INT_VEC_LO: imem_addr = INT_VEC_LO_ADDR;
      INT_VEC_HI: imem_addr = INT_VEC_HI_ADDR;
      RUN:        imem_addr = pc_r;
      default:    imem_addr = pc_r;
    endcase
  end

  // Fetch state machine, PC and saved_pc registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= RESET_STATE;
      pc_r       <= RESET_PC;
      saved_pc_r <= 32'h0000_0000;
    end else if (enable) begin
      case (state_r)
`ifdef FETCH_RESET_VECTOR_EN
        RST_VEC_LO: begin
          pc_r[15:0] <= imem_data;
          state_r    <= RST_VEC_HI;
        end
        RST_VEC_HI: begin
          pc_r[31:16] <= imem_data;
          state_r     <= RUN;
        end
`endif
        INT_VEC_LO: begin
          pc_r[15:0] <= imem_data;
          state_r    <= INT_VEC_HI;
        end
        INT_VEC_HI: begin
          pc_r[31:16] <= imem_data;
          state_r     <= RUN;
        end
        RUN: begin
          pc_r       <= pc_next_s;
          saved_pc_r <= saved_next_s;
          if (icu_pc_load) begin
            state_r <= INT_VEC_LO;
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end else begin
      state_r    <= state_r;
      pc_r       <= pc_r;
      saved_pc_r <= saved_pc_r;
    end
  end

  if_id_reg u_if_id_reg (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .load           (load_s),
    .flush          (flush_s),
    .hold           (hold_s),
    .instruction_in (load_instr_s),
    .pc_in          (pc_r),
    .instruction    (if_id_instruction),
    .pc             (if_id_pc),
    .valid          (if_id_valid)
  );

  assign saved_pc = saved_pc_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver advances a behavioural model
// each cycle and queues the expected IF/ID + saved_pc values; a monitor pops
// and compares after every rising edge.
module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, icu_req, icu_stall, icu_pc_load;
  logic        hazard_stall, branch_taken, if_id_valid;
  logic [15:0] icu_instruction, imem_data, if_id_instruction;
  logic [31:0] branch_target, imem_addr, if_id_pc, saved_pc;

  logic [15:0] mem [0:255];
  assign imem_data = mem[imem_addr[7:0]];

  fetch_stage dut (
    .clk(clk), .reset(reset), .enable(enable), .icu_req(icu_req),
    .icu_stall(icu_stall), .icu_instruction(icu_instruction),
    .icu_pc_load(icu_pc_load), .hazard_stall(hazard_stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .if_id_instruction(if_id_instruction), .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid), .saved_pc(saved_pc)
  );

`ifdef FETCH_RESET_VECTOR_EN
  localparam bit          VEC_ON = 1'b1;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
`else
  localparam bit          VEC_ON = 1'b0;
  localparam logic [31:0] RST_PC = 32'h0000_0004;
`endif

  typedef struct {
    logic [15:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        pc_known;
    logic [31:0] saved;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: PC, return address, decode register, vector progress
  logic [31:0] m_pc, m_saved, m_ifpc;
  logic [15:0] m_instr;
  logic        m_valid, m_pc_known;
  bit          m_in_vec;
  int          m_vw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bubble();
    m_instr = 16'h0000; m_valid = 1'b0; m_pc_known = 1'b0;
  endtask

  task automatic model_update();
    logic req, stall, win;
    logic [31:0] nxt;
    if (reset === 1'b0) begin
      m_pc = RST_PC; m_saved = 32'd0; m_instr = 16'd0; m_ifpc = 32'd0;
      m_valid = 1'b0; m_pc_known = 1'b1; m_in_vec = VEC_ON; m_vw = 0;
    end else if (enable === 1'b1) begin
      if (m_in_vec) begin
        if (m_vw % 2 == 0) m_pc[15:0] = mem[m_vw];
        else               m_pc[31:16] = mem[m_vw];
        bubble();
        if (m_vw % 2 == 1) m_in_vec = 1'b0;
        else               m_vw = m_vw + 1;
      end else begin
        req   = (icu_req === 1'b1);
        stall = (icu_stall === 1'b1);
        win   = req | stall;
        nxt   = m_pc;
        if (icu_pc_load) begin
          bubble(); m_in_vec = 1'b1; m_vw = 2;
        end else if (branch_taken) begin
          bubble(); nxt = branch_target;
        end else if (hazard_stall) begin
          // decode register and PC keep their values
        end else if (stall) begin
          bubble();
        end else if (req) begin
          m_instr = icu_instruction; m_ifpc = m_pc; m_valid = 1'b1; m_pc_known = 1'b1;
        end else begin
          m_instr = mem[m_pc[7:0]]; m_ifpc = m_pc; m_valid = 1'b1; m_pc_known = 1'b1;
          nxt = m_pc + 32'd1;
        end
        if (win) begin
          if (branch_taken) m_saved = branch_target;
        end else if (!(hazard_stall && !icu_pc_load && !branch_taken)) begin
          m_saved = nxt;
        end
        m_pc = nxt;
      end
    end
  endtask

  // One clock cycle: drive, check the address, advance model, queue expectation
  task automatic step(input logic rst, input logic en, input logic req, input logic stall,
                      input logic pl, input logic haz, input logic br,
                      input logic [15:0] ii, input logic [31:0] bt);
    exp_t e;
    @(negedge clk);
    reset = rst; enable = en; icu_req = req; icu_stall = stall; icu_pc_load = pl;
    hazard_stall = haz; branch_taken = br; icu_instruction = ii; branch_target = bt;
    #1;
    check("imem_addr", imem_addr, m_in_vec ? m_vw : m_pc);
    model_update();
    e.instr = m_instr; e.pc = m_ifpc; e.valid = m_valid; e.pc_known = m_pc_known; e.saved = m_saved;
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic nrm(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  // Monitor: compare DUT outputs with the queued expectation after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
        check("if_id_instruction", {16'd0, if_id_instruction}, {16'd0, e.instr});
        if (e.pc_known) check("if_id_pc", if_id_pc, e.pc);
        check("saved_pc", saved_pc, e.saved);
      end
    end
  end

  initial begin
    logic rq, st;
    int k;
    reset = 1'b0; enable = 1'b1; icu_req = 1'b0; icu_stall = 1'b0; icu_pc_load = 1'b0;
    hazard_stall = 1'b0; branch_taken = 1'b0; icu_instruction = 16'h0; branch_target = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0010; mem[1] = 16'h0000; mem[2] = 16'h0100; mem[3] = 16'h0001;
    m_pc = RST_PC; m_saved = 32'd0; m_instr = 16'd0; m_ifpc = 32'd0;
    m_valid = 1'b0; m_pc_known = 1'b1; m_in_vec = VEC_ON; m_vw = 0;

    // Reset and first fetch
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    check("reset_if_id_pc", if_id_pc, 32'h0);
    check("reset_saved_pc", saved_pc, 32'h0);
`ifdef FETCH_RESET_VECTOR_EN
    nrm(3);
    check("vec_reset_first_pc", if_id_pc, 32'h0000_0010);
`else
    nrm(1);
    check("noreset_vec_first_pc", if_id_pc, 32'h0000_0004);
`endif
    check("first_fetch_valid", {31'd0, if_id_valid}, 32'd1);

    // Injection window at PC 0x20
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 32'h0000_001F);
    nrm(1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    check("inject_bubble_valid", {31'd0, if_id_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h600A, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h6008, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h6009, 32'h0);
    check("inject_last_word", {16'd0, if_id_instruction}, 32'h0000_6009);
    check("inject_if_id_pc", if_id_pc, 32'h20);
    check("inject_saved_pc", saved_pc, 32'h20);
    check("inject_pc_held", imem_addr, 32'h20);

    // Interrupt vector
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
    nrm(2);
    check("intvec_fetch_addr", imem_addr, 32'h0001_0100);
    nrm(1);
    check("intvec_first_pc", if_id_pc, 32'h0001_0100);

    // Branch beats hazard
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 32'h0000_0080);
    check("br_haz_bubble", {31'd0, if_id_valid}, 32'd0);
    check("br_haz_pc", imem_addr, 32'h80);
    nrm(1);
    check("br_haz_fetch_pc", if_id_pc, 32'h80);

    // PC wrap
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 32'hFFFF_FFFF);
    nrm(1);
    check("wrap_next_pc", imem_addr, 32'h0);
    nrm(1);
    check("wrap_fetch_pc", if_id_pc, 32'h0);

    // Reset during the high interrupt-vector word, with enable low
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
    nrm(1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    check("midvec_reset_saved", saved_pc, 32'h0);
    check("midvec_reset_valid", {31'd0, if_id_valid}, 32'd0);
    check("midvec_reset_addr", imem_addr, VEC_ON ? 32'h0 : RST_PC);
    nrm(4);

    // Enable low holds everything
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 32'h1234);
    nrm(2);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      k  = $urandom_range(0, 19);
      rq = (k < 2) ? 1'b1 : ((k == 2) ? 1'bz : 1'b0);
      k  = $urandom_range(0, 19);
      st = (k < 2) ? 1'b1 : ((k == 2) ? 1'bz : 1'b0);
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) != 0), rq, st,
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 11) == 0), 16'($urandom), $urandom);
    end

    repeat (2) @(posedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
